// File: rtl/bridge_req_scheduler.sv
// Round-robin scheduler sharing one bridge request port between masters,
// with an in-order ID FIFO for response routing. Option: BRIDGE_ARB_LOCK_EN.
module bridge_req_scheduler #(
  parameter int N_MASTER        = 4,
  parameter int N_SLAVE         = 16,
  parameter int PAYLOAD_WIDTH   = 70,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDXW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_MASTER-1:0]               data_req_i,
  input  logic [N_MASTER*N_SLAVE-1:0]       data_dest_i,
  input  logic [N_MASTER*PAYLOAD_WIDTH-1:0] data_payload_i,
  output logic [N_MASTER-1:0]               data_gnt_o,
  output logic                              data_req_o,
  output logic [N_SLAVE-1:0]                data_dest_o,
  output logic [PAYLOAD_WIDTH-1:0]          data_payload_o,
  input  logic                              data_gnt_i,
  input  logic                              data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]             data_r_rdata_i,
  input  logic                              data_r_opc_i,
  output logic [N_MASTER-1:0]               data_r_valid_o,
  output logic [DATA_WIDTH-1:0]             data_r_rdata_o,
  output logic                              data_r_opc_o,
  output logic [CW-1:0]                     outstanding_o,
  output logic                              rsp_err_o
);

  logic [IDXW-1:0] rr_q, rr_d;
  logic [IDXW-1:0] rr_win;
  logic [IDXW-1:0] win;
  logic            any_req;

  logic [IDXW-1:0] mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic full, empty;
  logic push, pop;
  logic [IDXW-1:0] head;

  assign full    = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty   = (cnt_q == '0);
  assign any_req = |data_req_i;

  // Search upward from the rr pointer, wrapping at N_MASTER.
  always_comb begin
    int unsigned k;
    logic        found;
    rr_win = rr_q;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < N_MASTER; i++) begin
      k = (32'(rr_q) + 32'(i)) % 32'(N_MASTER);
      if (!found && data_req_i[k]) begin
        found  = 1'b1;
        rr_win = IDXW'(k);
      end
    end
  end

`ifdef BRIDGE_ARB_LOCK_EN
  logic            lock_vld_q;
  logic [IDXW-1:0] lock_idx_q;
  logic            lock_hit;

  assign lock_hit = lock_vld_q && data_req_i[lock_idx_q];
  assign win      = lock_hit ? lock_idx_q : rr_win;

  // Hold the stalled winner until it is granted or withdraws.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (data_req_o && !data_gnt_i) begin
      lock_vld_q <= 1'b1;
      lock_idx_q <= win;
    end else begin
      lock_vld_q <= 1'b0;
    end
  end
`else
  assign win = rr_win;
`endif

  assign data_req_o     = any_req && !full;
  assign data_dest_o    = data_dest_i[win*N_SLAVE +: N_SLAVE];
  assign data_payload_o = data_payload_i[win*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];

  assign push = data_req_o && data_gnt_i;
  assign pop  = data_r_valid_i && !empty;
  assign head = mem_q[rd_q];

  always_comb begin
    data_gnt_o = '0;
    if (push) data_gnt_o[win] = 1'b1;
  end

  always_comb begin
    data_r_valid_o = '0;
    if (pop) data_r_valid_o[head] = 1'b1;
  end

  assign data_r_rdata_o = data_r_rdata_i;
  assign data_r_opc_o   = data_r_opc_i;
  assign outstanding_o  = cnt_q;
  assign rsp_err_o      = err_q;

  always_comb begin
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      rr_d = (win == IDXW'(N_MASTER - 1)) ? '0 : win + 1'b1;
      wr_d = (wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
    end
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    if (data_r_valid_i && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= win;
    end
  end

endmodule

// File: tb/tb_bridge_req_scheduler.sv
// Directed bench for bridge_req_scheduler (4 masters, depth 4).
// Expected values are hand-computed per step.
module tb_bridge_req_scheduler;

  localparam int NM = 4;
  localparam int NS = 16;
  localparam int PL = 70;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic             clk;
  logic             rst_n;
  logic [NM-1:0]    req_i;
  logic [NM*NS-1:0] dest_i;
  logic [NM*PL-1:0] pay_i;
  logic [NM-1:0]    gnt_o;
  logic             req_o;
  logic [NS-1:0]    dest_o;
  logic [PL-1:0]    pay_o;
  logic             gnt_i;
  logic             rv_i;
  logic [DW-1:0]    rd_i;
  logic             opc_i;
  logic [NM-1:0]    rv_o;
  logic [DW-1:0]    rd_o;
  logic             opc_o;
  logic [CW-1:0]    outs_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  bridge_req_scheduler #(
    .N_MASTER(NM), .N_SLAVE(NS), .PAYLOAD_WIDTH(PL),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req_i), .data_dest_i(dest_i),
    .data_payload_i(pay_i), .data_gnt_o(gnt_o),
    .data_req_o(req_o), .data_dest_o(dest_o),
    .data_payload_o(pay_o), .data_gnt_i(gnt_i),
    .data_r_valid_i(rv_i), .data_r_rdata_i(rd_i),
    .data_r_opc_i(opc_i), .data_r_valid_o(rv_o),
    .data_r_rdata_o(rd_o), .data_r_opc_o(opc_o),
    .outstanding_o(outs_o), .rsp_err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] rq, input logic g,
                      input logic rv, input logic [31:0] rd,
                      input logic op);
    @(negedge clk);
    req_i = rq; gnt_i = g; rv_i = rv; rd_i = rd; opc_i = op;
    #1;
  endtask

  function automatic logic [NS-1:0] dst(input int m);
    dst = NS'(1) << (m * 3 + 1);
  endfunction

  function automatic logic [PL-1:0] pay(input int m);
    pay = {6'(m + 8), 32'hC0DE_0000 + 32'(m), 32'hA5A5_0000 + 32'(m)};
  endfunction

  initial begin
    for (int m = 0; m < NM; m++) begin
      dest_i[m*NS +: NS] = dst(m);
      pay_i[m*PL +: PL]  = pay(m);
    end
    rst_n = 1'b0; req_i = '0; gnt_i = 1'b0;
    rv_i = 1'b0; rd_i = '0; opc_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", 128'(outs_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_req", 128'(req_o), 128'(0));
    chk("rst_gnt", 128'(gnt_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // All masters requesting, bridge always granting.
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("g0", 128'(gnt_o), 128'(4'b0001));
    chk("g0_dest", 128'(dest_o), 128'(dst(0)));
    chk("g0_pay", 128'(pay_o), 128'(pay(0)));
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("g1", 128'(gnt_o), 128'(4'b0010));
    chk("g1_outs", 128'(outs_o), 128'(1));
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("g2", 128'(gnt_o), 128'(4'b0100));
    chk("g2_pay", 128'(pay_o), 128'(pay(2)));
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("g3", 128'(gnt_o), 128'(4'b1000));
    chk("g3_dest", 128'(dest_o), 128'(dst(3)));

    // Full: response in the same cycle must not allow issue.
    step(4'hF, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    chk("full_outs", 128'(outs_o), 128'(4));
    chk("full_req", 128'(req_o), 128'(0));
    chk("full_gnt", 128'(gnt_o), 128'(0));
    chk("rsp0_v", 128'(rv_o), 128'(4'b0001));
    chk("rsp0_d", 128'(rd_o), 128'(32'h1234_5678));
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("resume_req", 128'(req_o), 128'(1));
    chk("resume_gnt", 128'(gnt_o), 128'(4'b0001));
    chk("resume_outs", 128'(outs_o), 128'(3));
    step(4'h0, 1'b0, 1'b1, 32'hBEEF_0001, 1'b0);
    chk("rsp1_v", 128'(rv_o), 128'(4'b0010));
    chk("rsp1_outs", 128'(outs_o), 128'(4));
    step(4'h0, 1'b0, 1'b1, 32'hCAFE_0002, 1'b1);
    chk("rsp2_v", 128'(rv_o), 128'(4'b0100));
    chk("rsp2_d", 128'(rd_o), 128'(32'hCAFE_0002));
    chk("rsp2_opc", 128'(opc_o), 128'(1));

    // Push and pop together at count 2 (FIFO holds 3,0).
    step(4'b0100, 1'b1, 1'b1, 32'h0000_0003, 1'b0);
    chk("pp_outs", 128'(outs_o), 128'(2));
    chk("pp_gnt", 128'(gnt_o), 128'(4'b0100));
    chk("pp_v", 128'(rv_o), 128'(4'b1000));
    step(4'h0, 1'b0, 1'b1, 32'h0000_0004, 1'b0);
    chk("pp_after", 128'(outs_o), 128'(2));
    chk("wrap_v0", 128'(rv_o), 128'(4'b0001));
    step(4'h0, 1'b0, 1'b1, 32'h0000_0005, 1'b0);
    chk("wrap_v2", 128'(rv_o), 128'(4'b0100));

    // Response against an empty FIFO.
    step(4'h0, 1'b0, 1'b1, 32'h0000_0006, 1'b0);
    chk("empty_outs", 128'(outs_o), 128'(0));
    chk("empty_v", 128'(rv_o), 128'(0));
    chk("empty_err0", 128'(err_o), 128'(0));
    step(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("err_set", 128'(err_o), 128'(1));
    chk("err_outs", 128'(outs_o), 128'(0));
    step(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("err_sticky", 128'(err_o), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("err_clr", 128'(err_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Stalled m2, then m0 joins while bridge keeps refusing.
    step(4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_req", 128'(req_o), 128'(1));
    chk("stall_gnt", 128'(gnt_o), 128'(0));
    chk("stall_dest", 128'(dest_o), 128'(dst(2)));
    step(4'b0101, 1'b0, 1'b0, 32'h0, 1'b0);
    step(4'b0101, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef BRIDGE_ARB_LOCK_EN
    chk("lock_dest", 128'(dest_o), 128'(dst(2)));
    step(4'b0101, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("lock_gnt", 128'(gnt_o), 128'(4'b0100));
`else
    chk("nolock_dest", 128'(dest_o), 128'(dst(0)));
    step(4'b0101, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("nolock_gnt", 128'(gnt_o), 128'(4'b0001));
`endif

    // Reset with three outstanding discards them.
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    step(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("three_outs", 128'(outs_o), 128'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 128'(outs_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h0, 1'b0, 1'b1, 32'h0000_0007, 1'b0);
    chk("stale_v", 128'(rv_o), 128'(0));
    step(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stale_err", 128'(err_o), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
